// File: rtl/traffic_pkg.sv
// Shared types for the N-way intersection controller: lamp codes, phase
// encoding and the per-direction lamp decode helper.
package traffic_pkg;

   typedef enum logic [1:0] {
      LT_RED    = 2'b00,
      LT_YELLOW = 2'b01,
      LT_GREEN  = 2'b10
   } light_e;

   typedef enum logic [1:0] {
      PH_ALLRED  = 2'b00,
      PH_GREEN   = 2'b01,
      PH_YELLOW  = 2'b10,
      PH_PREEMPT = 2'b11
   } phase_e;

   // Lamp code for one direction slot of the lamp vector; only the owner of
   // the phase is ever lit, everyone else stays RED.
   function automatic light_e lamp_code(input phase_e ph, input logic owner);
      light_e c;
      c = LT_RED;
      if (owner) begin
         case (ph)
            PH_GREEN, PH_PREEMPT: c = LT_GREEN;
            PH_YELLOW:            c = LT_YELLOW;
            default:              c = LT_RED;
         endcase
      end
      return c;
   endfunction

   // Recover the lamp code held in one 2-bit slot of the lamp vector.
   function automatic light_e lamp_unpack(input logic [1:0] slot);
      return light_e'(slot);
   endfunction

endpackage

// File: rtl/traffic_next_dir_sel.sv
// Next-direction chooser: plain rotation in fixed-time mode, cyclic priority
// search over the demand inputs in actuated mode (current owner checked last).
module traffic_next_dir_sel #(
   parameter int NUM_DIR = 4,
   parameter int DIR_W   = $clog2(NUM_DIR)
) (
   input  logic [NUM_DIR-1:0] demand_i,
   input  logic [DIR_W-1:0]   active_dir_i,
   input  logic               mode_i,
   output logic [DIR_W-1:0]   next_dir_o
);

   logic             found;
   logic [DIR_W-1:0] idx;

   // Search active+1, active+2, ... active; fall back to simple rotation.
   always_comb begin
      next_dir_o = DIR_W'((32'(active_dir_i) + 32'd1) % NUM_DIR);
      found      = 1'b0;
      idx        = '0;
      if (mode_i) begin
         for (int k = 1; k <= NUM_DIR; k++) begin
            idx = DIR_W'((32'(active_dir_i) + 32'(k)) % NUM_DIR);
            if (!found && demand_i[idx]) begin
               next_dir_o = idx;
               found      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// N-way intersection controller: GREEN -> YELLOW -> ALL-RED rotation with
// fixed-time or demand-actuated selection and emergency preemption.
// All outputs come straight from registers.
module traffic_ctrl_multi
   import traffic_pkg::*;
#(
   parameter int NUM_DIR     = 4,
   parameter int GREEN_TIME  = 10,
   parameter int YELLOW_TIME = 4,
   parameter int ALLRED_TIME = 2,
   parameter int TIMER_W     = 8,
   localparam int DIR_W      = $clog2(NUM_DIR)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 mode,
   input  logic [NUM_DIR-1:0]   demand,
   input  logic                 preempt_req,
   input  logic [DIR_W-1:0]     preempt_dir,
   output logic [2*NUM_DIR-1:0] lights,
   output logic [DIR_W-1:0]     active_dir,
   output logic [1:0]           phase,
   output logic                 preempt_ack
);

   localparam logic [TIMER_W-1:0] G_END = TIMER_W'(GREEN_TIME - 1);
   localparam logic [TIMER_W-1:0] Y_END = TIMER_W'(YELLOW_TIME - 1);
   localparam logic [TIMER_W-1:0] A_END = TIMER_W'(ALLRED_TIME - 1);

   phase_e               phase_q, phase_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [DIR_W-1:0]     active_q, active_d;
   logic [DIR_W-1:0]     next_q, next_d;
   logic [DIR_W-1:0]     pdir_q, pdir_d, pdir_now;
   logic                 pend_q, pend_d, pend_now;
   logic [DIR_W-1:0]     sel_dir;
   logic [NUM_DIR-1:0]   own_mask;
   logic                 other_dem;
   logic [2*NUM_DIR-1:0] lights_q, lights_d;
   logic                 ack_q;

   assign own_mask  = NUM_DIR'(1) << active_q;
   assign other_dem = |(demand & ~own_mask);

   traffic_next_dir_sel #(
      .NUM_DIR (NUM_DIR),
      .DIR_W   (DIR_W)
   ) u_sel (
      .demand_i     (demand),
      .active_dir_i (active_q),
      .mode_i       (mode),
      .next_dir_o   (sel_dir)
   );

   // Phase sequencing; a live preemption request overrides the normal timing.
   always_comb begin
      phase_d  = phase_q;
      timer_d  = timer_q;
      active_d = active_q;
      next_d   = next_q;
      pend_d   = pend_q;
      pdir_d   = pdir_q;
      pend_now = 1'b0;
      pdir_now = pdir_q;
      if (en) begin
         // A request is pending while held high and not yet being served;
         // the direction is frozen at the first cycle it is seen.
         pend_now = preempt_req && (phase_q != PH_PREEMPT);
         pdir_now = pend_q ? pdir_q : preempt_dir;
         pend_d   = pend_now;
         pdir_d   = pdir_now;
         case (phase_q)
            PH_GREEN: begin
               if (pend_now) begin
                  timer_d = '0;
                  if (active_q == pdir_now) begin
                     phase_d = PH_PREEMPT;
                     pend_d  = 1'b0;
                  end else begin
                     phase_d = PH_YELLOW;
                  end
               end else if (timer_q == G_END) begin
                  // Actuated mode keeps green (timer parked) until someone else waits.
                  if (!mode || other_dem) begin
                     phase_d = PH_YELLOW;
                     timer_d = '0;
                  end
               end else begin
                  timer_d = timer_q + TIMER_W'(1);
               end
            end
            PH_YELLOW: begin
               if (timer_q == Y_END) begin
                  phase_d = PH_ALLRED;
                  timer_d = '0;
                  next_d  = pend_now ? pdir_now : sel_dir;
               end else begin
                  timer_d = timer_q + TIMER_W'(1);
               end
            end
            PH_ALLRED: begin
               if (timer_q == A_END) begin
                  timer_d = '0;
                  if (pend_now) begin
                     phase_d  = PH_PREEMPT;
                     active_d = pdir_now;
                     pend_d   = 1'b0;
                  end else begin
                     phase_d  = PH_GREEN;
                     active_d = next_q;
                  end
               end else begin
                  timer_d = timer_q + TIMER_W'(1);
               end
            end
            default: begin
               // PREEMPT: hold green on the served direction until released.
               if (!preempt_req) begin
                  phase_d = PH_YELLOW;
                  timer_d = '0;
               end
            end
         endcase
      end
   end

   // Lamp vector for the next state, so lights can be registered.
   always_comb begin
      lights_d = '0;
      for (int i = 0; i < NUM_DIR; i++) begin
         lights_d[2*i +: 2] = lamp_code(phase_d, active_d == DIR_W'(i));
      end
   end

   // State and output registers; reset forces everything RED at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= PH_ALLRED;
         timer_q  <= '0;
         active_q <= '0;
         next_q   <= '0;
         pend_q   <= 1'b0;
         pdir_q   <= '0;
         lights_q <= '0;
         ack_q    <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         timer_q  <= timer_d;
         active_q <= active_d;
         next_q   <= next_d;
         pend_q   <= pend_d;
         pdir_q   <= pdir_d;
         lights_q <= lights_d;
         ack_q    <= (phase_d == PH_PREEMPT);
      end
   end

   assign lights      = lights_q;
   assign active_dir  = active_q;
   assign phase       = phase_q;
   assign preempt_ack = ack_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi: directed scenarios plus randomized traffic,
// checked against a phase-length reference model through a scoreboard queue.
module tb_traffic_ctrl_multi;

   localparam int N  = 4;
   localparam int GT = 10;
   localparam int YT = 4;
   localparam int AT = 2;
   localparam int P_AR = 0, P_G = 1, P_Y = 2, P_P = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] demand = '0;
   logic       preempt_req = 1'b0;
   logic [1:0] preempt_dir = '0;
   logic [7:0] lights;
   logic [1:0] active_dir;
   logic [1:0] phase;
   logic       preempt_ack;

   always #5 clk = ~clk;

   traffic_ctrl_multi #(
      .NUM_DIR     (N),
      .GREEN_TIME  (GT),
      .YELLOW_TIME (YT),
      .ALLRED_TIME (AT),
      .TIMER_W     (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .mode        (mode),
      .demand      (demand),
      .preempt_req (preempt_req),
      .preempt_dir (preempt_dir),
      .lights      (lights),
      .active_dir  (active_dir),
      .phase       (phase),
      .preempt_ack (preempt_ack)
   );

   typedef struct packed {
      logic [7:0] l;
      logic [1:0] a;
      logic [1:0] p;
      logic       k;
   } exp_t;

   exp_t sbq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: phase, owning direction, and how many cycles the
   // current phase has already been on display.
   int m_ph, m_dir, m_cnt, m_next, m_pdir;
   bit m_pend;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
      end
   endtask

   function automatic int pick(input bit md, input logic [3:0] dm, input int d);
      if (md) begin
         for (int k = 1; k <= N; k++) begin
            if (dm[(d + k) % N]) return (d + k) % N;
         end
      end
      return (d + 1) % N;
   endfunction

   function automatic void enter(input int p);
      m_ph  = p;
      m_cnt = 1;
   endfunction

   function automatic void model_step(input bit e, input bit md, input logic [3:0] dm,
                                      input bit pr, input int pdi);
      bit pend;
      int pd;
      bit moved;
      if (!e) return;
      pend   = pr && (m_ph != P_P);
      pd     = m_pend ? m_pdir : pdi;
      m_pend = pend;
      m_pdir = pd;
      moved  = 1'b0;
      case (m_ph)
         P_G: begin
            if (pend) begin
               if (m_dir == pd) begin
                  enter(P_P);
                  m_pend = 1'b0;
               end else begin
                  enter(P_Y);
               end
               moved = 1'b1;
            end else if (m_cnt >= GT && (!md || (dm & ~(4'b0001 << m_dir)) != 4'b0000)) begin
               enter(P_Y);
               moved = 1'b1;
            end
         end
         P_Y: begin
            if (m_cnt == YT) begin
               m_next = pend ? pd : pick(md, dm, m_dir);
               enter(P_AR);
               moved = 1'b1;
            end
         end
         P_AR: begin
            if (m_cnt == AT) begin
               if (pend) begin
                  m_dir  = pd;
                  m_pend = 1'b0;
                  enter(P_P);
               end else begin
                  m_dir = m_next;
                  enter(P_G);
               end
               moved = 1'b1;
            end
         end
         default: begin
            if (!pr) begin
               enter(P_Y);
               moved = 1'b1;
            end
         end
      endcase
      if (!moved) m_cnt++;
   endfunction

   function automatic exp_t exp_now();
      exp_t e;
      logic [1:0] code;
      e = '0;
      code = (m_ph == P_G || m_ph == P_P) ? 2'b10 : (m_ph == P_Y) ? 2'b01 : 2'b00;
      e.l[2*m_dir +: 2] = code;
      e.a = 2'(m_dir);
      e.p = 2'(m_ph);
      e.k = (m_ph == P_P);
      return e;
   endfunction

   // One clock: drive inputs, predict the state after the coming edge, wait.
   task automatic cyc(input bit e, input bit md, input logic [3:0] dm,
                      input bit pr, input logic [1:0] pd);
      en          = e;
      mode        = md;
      demand      = dm;
      preempt_req = pr;
      preempt_dir = pd;
      model_step(e, md, dm, pr, int'(pd));
      sbq.push_back(exp_now());
      @(posedge clk);
      #1;
   endtask

   // Async reset between edges, immediate output check, release one cycle later.
   task automatic do_reset();
      rst_n = 1'b0;
      sbq.delete();
      #1;
      chk("rst_lights", 32'(lights), 32'd0);
      chk("rst_phase", 32'(phase), 32'd0);
      chk("rst_ack", 32'(preempt_ack), 32'd0);
      chk("rst_active", 32'(active_dir), 32'd0);
      m_ph = P_AR; m_cnt = 1; m_dir = 0; m_next = 0; m_pend = 1'b0; m_pdir = 0;
      en = 1'b1; mode = 1'b0; demand = '0; preempt_req = 1'b0; preempt_dir = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sbq.push_back(exp_now());
   endtask

   task automatic scen1(input string tag);
      for (int i = 0; i < 70; i++) begin
         cyc(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
         if (i + 1 == 12) chk({tag, "_y0_at12"}, 32'({phase, active_dir}), 32'b1000);
         if (i + 1 == 18) chk({tag, "_g1_at18"}, 32'({phase, active_dir}), 32'b0101);
         if (i + 1 == 66) chk({tag, "_g0_at66"}, 32'({phase, active_dir}), 32'b0100);
      end
   endtask

   // Monitor: every settled cycle the DUT presents is compared to the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("sb_lights", 32'(lights), 32'(e.l));
            chk("sb_active", 32'(active_dir), 32'(e.a));
            chk("sb_phase", 32'(phase), 32'(e.p));
            chk("sb_ack", 32'(preempt_ack), 32'(e.k));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin
      bit         reached;
      bit         md;
      bit         pr;
      logic [3:0] dm;

      @(posedge clk);
      #1;

      // Fixed-time rotation from reset.
      do_reset();
      scen1("s1");

      // Actuated skip of an idle direction.
      do_reset();
      for (int i = 0; i < 24; i++) begin
         cyc(1'b1, 1'b1, 4'b0100, 1'b0, 2'd0);
         if (i + 1 == 12) chk("s2_y0_at12", 32'({phase, active_dir}), 32'b1000);
         if (i + 1 == 18) chk("s2_g2_at18", 32'({phase, active_dir}), 32'b0110);
      end

      // Actuated green extension until another direction calls.
      do_reset();
      for (int i = 0; i < 45; i++) begin
         cyc(1'b1, 1'b1, (i >= 30) ? 4'b1000 : 4'b0000, 1'b0, 2'd0);
         if (i + 1 == 30) chk("s3_hold_at30", 32'({phase, active_dir}), 32'b0100);
         if (i + 1 == 31) chk("s3_y0_at31", 32'({phase, active_dir}), 32'b1000);
         if (i + 1 == 37) chk("s3_g3_at37", 32'({phase, active_dir}), 32'b0111);
      end

      // Preemption truncating dir1 green in favour of dir3.
      do_reset();
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
         if (m_ph == P_G && m_dir == 1 && m_cnt == 4) reached = 1'b1;
         else cyc(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      end
      chk("s4_reach", 32'(reached), 32'd1);
      for (int i = 0; i < 25; i++) begin
         cyc(1'b1, 1'b0, 4'b0000, 1'b1, (i == 0) ? 2'd3 : 2'($urandom));
         if (i == 0)  chk("s4_y1", 32'({preempt_ack, phase, active_dir}), 32'b0_10_01);
         if (i == 6)  chk("s4_pre3", 32'({preempt_ack, phase, active_dir}), 32'b1_11_11);
         if (i == 24) chk("s4_pre3_held", 32'({preempt_ack, phase, active_dir}), 32'b1_11_11);
      end
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
         if (i == 0) chk("s4_y3", 32'({preempt_ack, phase, active_dir}), 32'b0_10_11);
         if (i == 6) chk("s4_g0", 32'({preempt_ack, phase, active_dir}), 32'b0_01_00);
      end

      // Freeze during dir2 green.
      do_reset();
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
         if (m_ph == P_G && m_dir == 2 && m_cnt == 7) reached = 1'b1;
         else cyc(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      end
      chk("s5_reach", 32'(reached), 32'd1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
      chk("s5_frozen", 32'({phase, active_dir}), 32'b0110);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
         if (i == 2) chk("s5_last_green", 32'({phase, active_dir}), 32'b0110);
         if (i == 3) chk("s5_yellow", 32'({phase, active_dir}), 32'b1010);
      end

      // Randomized traffic, modes, freezes and preemption bursts.
      md = 1'b0; pr = 1'b0; dm = '0;
      for (int c = 0; c < 1500; c++) begin
         if (c % 100 == 0) md = 1'($urandom);
         if ($urandom_range(0, 7) == 0) dm = 4'($urandom);
         if (!pr && $urandom_range(0, 39) == 0) pr = 1'b1;
         else if (pr && $urandom_range(0, 11) == 0) pr = 1'b0;
         cyc($urandom_range(0, 15) != 0, md, dm, pr, 2'($urandom));
      end

      // Reset in the middle of a yellow, then the cold-start sequence again.
      do_reset();
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
         if (m_ph == P_Y && m_cnt == 2) reached = 1'b1;
         else cyc(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
      end
      chk("s6_reach", 32'(reached), 32'd1);
      chk("s6_in_yellow", 32'(phase), 32'b10);
      do_reset();
      scen1("s6");

      repeat (2) @(negedge clk);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
